// File: rtl/lstm_pkg.sv
// Shared Q8.8 fixed-point definitions for the LSTM datapath blocks.
package lstm_pkg;

  localparam int DW     = 16;
  localparam int FRAC_W = 8;

  localparam logic signed [DW-1:0] Q_ONE  = 16'sh0100;
  localparam logic signed [DW-1:0] Q_HALF = 16'sh0080;
  localparam logic signed [DW-1:0] Q_MAX  = 16'sh7FFF;
  localparam logic signed [DW-1:0] Q_MIN  = 16'sh8000;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_FULL    = 1'b1
  } collect_state_e;

endpackage

// File: rtl/gate_sat_add.sv
// Combinational 3-input Q8.8 add with saturation; optional hard sigmoid when
// GATE_HARD_SIGMOID_EN is defined. sat reports adder saturation only.
module gate_sat_add
  import lstm_pkg::*;
(
  input  logic [DW-1:0] data_x,
  input  logic [DW-1:0] data_h,
  input  logic [DW-1:0] bias,
  output logic [DW-1:0] value,
  output logic          sat
);

  logic signed [DW+1:0] sum;
  logic signed [DW-1:0] sat_val;
`ifdef GATE_HARD_SIGMOID_EN
  logic signed [DW-1:0] hs_val;
`endif

  // Two guard bits are enough for the sum of three 16-bit signed operands.
  assign sum = $signed({{2{data_x[DW-1]}}, data_x})
             + $signed({{2{data_h[DW-1]}}, data_h})
             + $signed({{2{bias[DW-1]}}, bias});

  always_comb begin
    sat     = 1'b0;
    sat_val = sum[DW-1:0];
    if (sum > 18'sd32767) begin
      sat     = 1'b1;
      sat_val = Q_MAX;
    end else if (sum < -18'sd32768) begin
      sat     = 1'b1;
      sat_val = Q_MIN;
    end
  end

`ifdef GATE_HARD_SIGMOID_EN
  assign hs_val = (sat_val >>> 2) + Q_HALF;

  always_comb begin
    value = hs_val;
    if (hs_val < 16'sd0)
      value = '0;
    else if (hs_val > Q_ONE)
      value = Q_ONE;
  end
`else
  assign value = sat_val;
`endif

endmodule

// File: rtl/vecmat_gate_collect.sv
// Collects per-neuron gate results (x + h + bias, saturated) into one packed
// gate vector with valid/ready output. Optional hard sigmoid: GATE_HARD_SIGMOID_EN.
module vecmat_gate_collect
  import lstm_pkg::*;
#(
  parameter int ARRAY_DEPTH = 64,
  parameter int VEC_W       = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    data_x,
  input  logic [DW-1:0]    data_h,
  input  logic [DW-1:0]    bias,
  output logic [VEC_W-1:0] gate_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sat_flag
);

  localparam int CW = $clog2(ARRAY_DEPTH + 1);
  localparam int IW = $clog2(ARRAY_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(ARRAY_DEPTH);
  localparam logic [IW-1:0] LAST_C  = IW'(ARRAY_DEPTH - 1);

  collect_state_e state_q;
  logic [CW-1:0]  acc_cnt_q;
  logic           s1_valid_q;
  logic [DW-1:0]  s1_val_q;
  logic           s1_sat_q;
  logic [IW-1:0]  s1_idx_q;
  logic           out_valid_q;
  logic           sat_flag_q;
  logic [DW-1:0]  slot_q [ARRAY_DEPTH];

  logic [DW-1:0]  add_val;
  logic           add_sat;
  logic           accept;

  gate_sat_add u_sat_add (
    .data_x (data_x),
    .data_h (data_h),
    .bias   (bias),
    .value  (add_val),
    .sat    (add_sat)
  );

  assign in_ready  = (state_q == ST_COLLECT) && (acc_cnt_q < DEPTH_C);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign sat_flag  = sat_flag_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_COLLECT;
      acc_cnt_q   <= '0;
      s1_valid_q  <= 1'b0;
      s1_val_q    <= '0;
      s1_sat_q    <= 1'b0;
      s1_idx_q    <= '0;
      out_valid_q <= 1'b0;
      sat_flag_q  <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_val_q <= add_val;
        s1_sat_q <= add_sat;
        s1_idx_q <= acc_cnt_q[IW-1:0];
      end
      case (state_q)
        ST_COLLECT: begin
          if (accept)
            acc_cnt_q <= acc_cnt_q + 1'b1;
          if (s1_valid_q) begin
            sat_flag_q <= sat_flag_q | s1_sat_q;
            if (s1_idx_q == LAST_C) begin
              state_q     <= ST_FULL;
              out_valid_q <= 1'b1;
            end
          end
        end
        ST_FULL: begin
          if (out_valid_q && out_ready) begin
            state_q     <= ST_COLLECT;
            out_valid_q <= 1'b0;
            acc_cnt_q   <= '0;
            sat_flag_q  <= 1'b0;
          end
        end
        default: state_q <= ST_COLLECT;
      endcase
    end
  end

  // Slots are only rewritten by the next vector, so gate_vec holds across the handshake.
  for (genvar gi = 0; gi < ARRAY_DEPTH; gi++) begin : g_slot
    always_ff @(posedge clk) begin
      if (!reset)
        slot_q[gi] <= '0;
      else if (s1_valid_q && (s1_idx_q == IW'(gi)))
        slot_q[gi] <= s1_val_q;
    end
    assign gate_vec[gi*DW +: DW] = slot_q[gi];
  end

endmodule

// File: tb/tb_vecmat_gate_collect.sv
// Randomized self-checking bench for vecmat_gate_collect with a Q8.8 arithmetic reference model.
module tb_vecmat_gate_collect;

  localparam int N = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   data_x, data_h, bias;
  logic [1023:0] gate_vec;
  logic          out_valid;
  logic          out_ready;
  logic          sat_flag;

  int checks = 0;
  int errors = 0;

  logic [15:0] vx [N];
  logic [15:0] vh [N];
  logic [15:0] vb [N];
  logic [15:0] exp_v [N];
  logic        exp_sat;

  vecmat_gate_collect dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_x    (data_x),
    .data_h    (data_h),
    .bias      (bias),
    .gate_vec  (gate_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sat_flag  (sat_flag)
  );

  always #5 clk = ~clk;

  // Returns {sat, value} from plain integer arithmetic.
  function automatic logic [16:0] ref_model(logic [15:0] x, logic [15:0] h, logic [15:0] b);
    int s;
    int y;
    logic sat;
    s   = int'($signed(x)) + int'($signed(h)) + int'($signed(b));
    sat = 1'b0;
    if (s > 32767) begin
      s = 32767; sat = 1'b1;
    end else if (s < -32768) begin
      s = -32768; sat = 1'b1;
    end
    y = s;
`ifdef GATE_HARD_SIGMOID_EN
    if (s >= 0) y = s / 4;
    else        y = -((-s + 3) / 4);
    y = y + 128;
    if (y < 0)   y = 0;
    if (y > 256) y = 256;
`endif
    return {sat, y[15:0]};
  endfunction

  function automatic logic [15:0] small_rand();
    logic [15:0] r;
    r = 16'($urandom);
    return {{4{r[11]}}, r[11:0]};
  endfunction

  task automatic build_expected();
    logic [16:0] r;
    exp_sat = 1'b0;
    for (int i = 0; i < N; i++) begin
      r        = ref_model(vx[i], vh[i], vb[i]);
      exp_v[i] = r[15:0];
      exp_sat  = exp_sat | r[16];
    end
  endtask

  task automatic fill_small();
    for (int i = 0; i < N; i++) begin
      vx[i] = small_rand(); vh[i] = small_rand(); vb[i] = small_rand();
    end
  endtask

  // Drives elements 0..n-1; returns right after the posedge that accepts the last one.
  task automatic run_vector(int n, int idle_pct);
    bit accepted;
    int tries;
    for (int i = 0; i < n; i++) begin
      accepted = 1'b0;
      tries    = 0;
      while (!accepted) begin
        @(negedge clk);
        if (int'($urandom_range(99)) < idle_pct) begin
          in_valid = 1'b0;
        end else begin
          in_valid = 1'b1;
          data_x = vx[i]; data_h = vh[i]; bias = vb[i];
          accepted = in_ready;
        end
        @(posedge clk);
        tries++;
        if (tries > 500) begin
          checks++; errors++;
          $display("FAIL accept_timeout: element %0d not accepted after %0d cycles, required acceptance", i, tries);
          return;
        end
      end
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat_flag: got %b want 0", sat_flag); end
    checks++;
    if (gate_vec !== '0) begin errors++; $display("FAIL reset_gate_vec: got nonzero %h want 0", gate_vec[63:0]); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    $display("test_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_basic_fill();
    int bad;
    for (int i = 0; i < N; i++) begin
      vx[i] = 16'h0100; vh[i] = 16'h0080; vb[i] = 16'h0001;
    end
    build_expected();
    run_vector(N, 0);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_latency_early: out_valid=%b want 0", out_valid); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: out_valid=%b want 1", out_valid); end
    bad = 0;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (gate_vec[i*16 +: 16] !== exp_v[i]) begin
        errors++; bad++;
        $display("FAIL basic_slot%0d: got %h want %h", i, gate_vec[i*16 +: 16], exp_v[i]);
      end
    end
`ifndef GATE_HARD_SIGMOID_EN
    checks++;
    if (gate_vec[63*16 +: 16] !== 16'h0181) begin errors++; $display("FAIL basic_const: got %h want 0181", gate_vec[63*16 +: 16]); end
`endif
    checks++;
    if (sat_flag !== 1'b0) begin errors++; $display("FAIL basic_sat_flag: got %b want 0", sat_flag); end
    handshake();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL basic_handshake: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    $display("test_basic_fill done: bad slots=%0d", bad);
  endtask

  task automatic test_saturation();
    bit ok;
    fill_small();
    vx[5] = 16'h7000; vh[5] = 16'h7000; vb[5] = 16'h0000;
    vx[6] = 16'h9000; vh[6] = 16'h9000; vb[6] = 16'h0000;
    build_expected();
    run_vector(N, 0);
    wait_valid(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL sat_valid_timeout: out_valid never rose, want 1"); end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (gate_vec[i*16 +: 16] !== exp_v[i]) begin
        errors++; $display("FAIL sat_slot%0d: got %h want %h", i, gate_vec[i*16 +: 16], exp_v[i]);
      end
    end
`ifndef GATE_HARD_SIGMOID_EN
    checks++;
    if (gate_vec[5*16 +: 16] !== 16'h7FFF || gate_vec[6*16 +: 16] !== 16'h8000) begin
      errors++; $display("FAIL sat_consts: slot5=%h slot6=%h want 7fff/8000", gate_vec[5*16 +: 16], gate_vec[6*16 +: 16]);
    end
`endif
    checks++;
    if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_flag_set: got %b want 1", sat_flag); end
    handshake();
    checks++;
    if (sat_flag !== 1'b0) begin errors++; $display("FAIL sat_flag_clear: got %b want 0", sat_flag); end
    $display("test_saturation done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_back_pressure();
    bit ok;
    logic [1023:0] snap;
    fill_small();
    build_expected();
    run_vector(N, 0);
    wait_valid(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_valid_timeout: out_valid never rose, want 1"); end
    snap = gate_vec;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      data_x = 16'($urandom); data_h = 16'($urandom); bias = 16'($urandom);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || gate_vec !== snap) begin
        errors++;
        $display("FAIL bp_hold%0d: in_ready=%b out_valid=%b stable=%b want 0/1/1", c, in_ready, out_valid, gate_vec === snap);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_pre_handshake_ready: got %b want 0", in_ready); end
    handshake();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    fill_small();
    build_expected();
    run_vector(N, 0);
    wait_valid(ok);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (gate_vec[i*16 +: 16] !== exp_v[i]) begin
        errors++; $display("FAIL bp_next_slot%0d: got %h want %h", i, gate_vec[i*16 +: 16], exp_v[i]);
      end
    end
    handshake();
    $display("test_back_pressure done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_bubbles();
    bit ok;
    for (int v = 0; v < 2; v++) begin
      for (int i = 0; i < N; i++) begin
        vx[i] = 16'($urandom); vh[i] = 16'($urandom); vb[i] = 16'($urandom);
      end
      build_expected();
      run_vector(N, 50);
      @(negedge clk);
      in_valid = 1'b1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bubble_count%0d: in_ready=%b after 64 accepts, want 0", v, in_ready); end
      wait_valid(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL bubble_valid_timeout%0d: out_valid never rose, want 1", v); end
      for (int i = 0; i < N; i++) begin
        checks++;
        if (gate_vec[i*16 +: 16] !== exp_v[i]) begin
          errors++; $display("FAIL bubble%0d_slot%0d: got %h want %h", v, i, gate_vec[i*16 +: 16], exp_v[i]);
        end
      end
      checks++;
      if (sat_flag !== exp_sat) begin errors++; $display("FAIL bubble%0d_sat_flag: got %b want %b", v, sat_flag, exp_sat); end
      handshake();
      $display("test_bubbles vector %0d done: checks=%0d errors=%0d", v, checks, errors);
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    for (int i = 0; i < N; i++) begin
      vx[i] = 16'h7000; vh[i] = 16'h7000; vb[i] = 16'h0000;
    end
    run_vector(30, 0);
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || sat_flag !== 1'b0 || in_ready !== 1'b1 || gate_vec !== '0) begin
      errors++;
      $display("FAIL mid_reset_state: out_valid=%b sat_flag=%b in_ready=%b vec_zero=%b want 0/0/1/1",
               out_valid, sat_flag, in_ready, gate_vec === '0);
    end
    fill_small();
    build_expected();
    run_vector(N, 20);
    wait_valid(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mid_reset_valid_timeout: out_valid never rose, want 1"); end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (gate_vec[i*16 +: 16] !== exp_v[i]) begin
        errors++; $display("FAIL mid_reset_slot%0d: got %h want %h", i, gate_vec[i*16 +: 16], exp_v[i]);
      end
    end
    checks++;
    if (sat_flag !== 1'b0) begin errors++; $display("FAIL mid_reset_sat_flag: got %b want 0", sat_flag); end
    handshake();
    $display("test_mid_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

`ifdef GATE_HARD_SIGMOID_EN
  task automatic test_hard_sigmoid();
    bit ok;
    logic [15:0] want [4];
    fill_small();
    vx[0] = 16'h0000; vx[1] = 16'h0400; vx[2] = 16'hFC00; vx[3] = 16'h0100;
    want[0] = 16'h0080; want[1] = 16'h0100; want[2] = 16'h0000; want[3] = 16'h00C0;
    for (int i = 0; i < 4; i++) begin
      vh[i] = 16'h0000; vb[i] = 16'h0000;
    end
    build_expected();
    run_vector(N, 0);
    wait_valid(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL hs_valid_timeout: out_valid never rose, want 1"); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (gate_vec[i*16 +: 16] !== want[i]) begin
        errors++; $display("FAIL hs_const%0d: got %h want %h", i, gate_vec[i*16 +: 16], want[i]);
      end
    end
    for (int i = 4; i < N; i++) begin
      checks++;
      if (gate_vec[i*16 +: 16] !== exp_v[i]) begin
        errors++; $display("FAIL hs_slot%0d: got %h want %h", i, gate_vec[i*16 +: 16], exp_v[i]);
      end
    end
    handshake();
    $display("test_hard_sigmoid done: checks=%0d errors=%0d", checks, errors);
  endtask
`endif

  initial begin
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    data_x = '0; data_h = '0; bias = '0;
    test_reset();
    test_basic_fill();
    test_saturation();
    test_back_pressure();
    test_bubbles();
    test_mid_reset();
`ifdef GATE_HARD_SIGMOID_EN
    test_hard_sigmoid();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
